block_stream_sender: RTL and testbench
======================================

# block_stream_sender

Producer side of the per-block pixel stream consumed by `noise_estimation`. It buffers pixels from an upstream valid/ready source and re-emits them as gap-separated, strictly contiguous blocks of `TOTAL_SAMPLES` samples. It asserts `start_of_frame`/`start_data` with each block's first sample and `end_of_frame` during the frame's last block. It sits between the frame source (DMA/pixel reader) and the noise estimator, which has no stall input and therefore must never see a bubble inside a block.

## Interface
- `DATA_WIDTH`, 8, pixel width.
- `TOTAL_SAMPLES`, 64, samples per block; power of two, ≥2.
- `GAP_CYCLES`, 2, idle cycles between consecutive blocks; must be ≥1.
- `clk` input 1: the single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `frame_start` input 1: one-cycle request to send a frame.
- `blocks_per_frame` input 32: block count, sampled on an accepted `frame_start`.
- `s_valid` input 1: upstream pixel valid.
- `s_data` input DATA_WIDTH: upstream pixel.
- `s_ready` output 1: buffer can accept; combinational, `count < 2*TOTAL_SAMPLES`.
- `data_out` output DATA_WIDTH: pixel to estimator (`data_in` there).
- `data_valid` output 1: `data_out` carries a block sample.
- `start_data` output 1: first sample of every block.
- `start_of_frame` output 1: first sample of first block.
- `end_of_frame` output 1: high for every sample of the last block.
- `busy` output 1: frame in progress.
- `frame_done` output 1: one-cycle pulse after the last sample of the frame.

## Operation
- Buffer: circular FIFO, depth `2*TOTAL_SAMPLES`, with an occupancy `count`.
  - Push on `s_valid && s_ready`. Pop on each emitted sample.
  - A simultaneous push and pop leaves `count` unchanged.
  - Pushes are accepted in every state, including IDLE (prefill allowed).
- FSM states: IDLE, WAIT_DATA, SEND, GAP.
- IDLE:
  - `frame_start` with `blocks_per_frame != 0`: latch it into `blocks_left`, go to WAIT_DATA.
  - `frame_start` with `blocks_per_frame == 0`: ignored; no outputs change.
- WAIT_DATA: when `count >= TOTAL_SAMPLES`, go to SEND.
  - Starting a block only from a full block of buffered data guarantees the block is bubble-free.
- SEND:
  - Emits exactly `TOTAL_SAMPLES` samples on consecutive cycles, using sample counter `idx`.
  - After the last sample, decrement `blocks_left`.
  - If `blocks_left` was 1: go to IDLE and pulse `frame_done`. Otherwise go to GAP.
- GAP: hold for `GAP_CYCLES` cycles with `data_valid=0`, then go to WAIT_DATA.
- Flag generation:
  - `start_data` = (`idx==0`) in SEND.
  - `start_of_frame` = `start_data` of the frame's first block.
  - `end_of_frame` = SEND && `blocks_left==1`.
- `frame_start` while `busy` is ignored. `blocks_per_frame` changes mid-frame have no effect.
- `data_out` holds its last emitted value when `data_valid=0`.
- Counters: `blocks_left` is 32-bit. `idx` is `$clog2(TOTAL_SAMPLES)` bits and wraps to 0 after the last sample. `count` is `$clog2(2*TOTAL_SAMPLES)+1` bits.

## Timing
- Reset values:
  - All registered outputs are 0: `data_out`, `data_valid`, `start_data`, `start_of_frame`, `end_of_frame`, `busy`, `frame_done`.
  - FIFO is empty, so `s_ready=1`.
  - FSM is IDLE; `blocks_left=0`.
- All outputs except `s_ready` are registered.
- `frame_start` accepted at edge T: `busy=1` from T+1.
- WAIT_DATA with `count>=TOTAL_SAMPLES` at edge E: the first sample appears at E+1 with `data_valid=start_data=1`.
- With a prefilled buffer, the first sample appears at T+2.
- A block occupies exactly `TOTAL_SAMPLES` cycles of `data_valid=1`.
- The next block's first sample comes no earlier than `GAP_CYCLES+1` cycles after the previous last sample. It is later if data is short.
- `frame_done` is high for the one cycle after the last sample. `busy` falls in that same cycle.
- Reset asserted mid-frame: immediate return to reset values, FIFO contents discarded. No partial block continues after release.

## Test plan
- Prefilled frame (`TOTAL_SAMPLES=4`, `GAP_CYCLES=2`): prefill 16 pixels 4,8,…,64, then `frame_start` with `blocks_per_frame=4`.
  - Required: four 4-sample bursts carrying 4..64 in order.
  - `start_of_frame` only on the sample 4.
  - `start_data` on samples 4, 20, 36, 52.
  - `end_of_frame` on 52..64.
  - Exactly 2 idle cycles between bursts; `frame_done` once.
- Starved source: pixels arrive one every 3 cycles.
  - Required: no block starts before 4 samples are buffered.
  - `data_valid` is never low inside a block.
- Backpressure: hold `s_valid=1` with no frame active.
  - Required: `s_ready` drops after 8 accepted pushes.
  - After `frame_start` with `blocks_per_frame=2`, `s_ready` reasserts as samples pop; all 8 samples emerge in order.
- Ignored requests:
  - `frame_start` with `blocks_per_frame=0`: `busy` stays 0.
  - Second `frame_start` mid-frame: the frame still ends after the originally latched block count.
- Mid-frame reset: assert `rst_n=0` during the second sample of block 2.
  - Required: all outputs 0 asynchronously and `s_ready=1`.
  - A new frame after release restarts with `start_of_frame`.
- Single-block frame: `blocks_per_frame=1`.
  - Required: `start_of_frame`, `start_data`, `end_of_frame` all high on the first sample.
  - `end_of_frame` stays high for all 4 samples; `frame_done` follows the 4th sample.

Source files
------------

// File: rtl/block_stream_sender.sv
// block_stream_sender: buffers upstream pixels and replays them as
// bubble-free, gap-separated blocks for the noise estimator.
module block_stream_sender #(
    parameter int DATA_WIDTH    = 8,
    parameter int TOTAL_SAMPLES = 64,
    parameter int GAP_CYCLES    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [31:0]           blocks_per_frame,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  start_data,
    output logic                  start_of_frame,
    output logic                  end_of_frame,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int DEPTH = 2 * TOTAL_SAMPLES;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int IW    = $clog2(TOTAL_SAMPLES);
    localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SEND,
        ST_GAP
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr;
    logic [AW-1:0]         r_rd;
    logic [CW-1:0]         r_count;

    state_t                r_state;
    logic [31:0]           r_blocks_left;
    logic [IW-1:0]         r_idx;
    logic [GW-1:0]         r_gap;
    logic                  r_first;

    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_data_valid;
    logic                  r_start_data;
    logic                  r_sof;
    logic                  r_eof;
    logic                  r_busy;
    logic                  r_frame_done;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_have_block;
    logic                  w_last_blk;
    logic                  w_last_idx;

    assign s_ready      = (r_count < CW'(DEPTH));
    assign w_push       = s_valid && s_ready;
    assign w_have_block = (r_count >= CW'(TOTAL_SAMPLES));
    assign w_last_blk   = (r_blocks_left == 32'd1);
    assign w_last_idx   = (r_idx == IW'(TOTAL_SAMPLES - 1));
    // A block only launches from a full block of buffered data, so
    // every pop inside SEND is guaranteed to find a sample.
    assign w_pop        = (r_state == ST_SEND) ||
                          ((r_state == ST_WAIT) && w_have_block);

    assign data_out       = r_data_out;
    assign data_valid     = r_data_valid;
    assign start_data     = r_start_data;
    assign start_of_frame = r_sof;
    assign end_of_frame   = r_eof;
    assign busy           = r_busy;
    assign frame_done     = r_frame_done;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_blocks_left <= '0;
            r_idx         <= '0;
            r_gap         <= '0;
            r_first       <= 1'b0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_start_data  <= 1'b0;
            r_sof         <= 1'b0;
            r_eof         <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            r_start_data <= 1'b0;
            r_sof        <= 1'b0;
            r_eof        <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_pop) begin
                r_data_out <= r_mem[r_rd];
            end
            unique case (r_state)
                ST_IDLE: begin
                    // busy still set here means the frame just ended
                    if (r_busy) begin
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end else if (frame_start && (blocks_per_frame != 32'd0)) begin
                        r_blocks_left <= blocks_per_frame;
                        r_busy        <= 1'b1;
                        r_first       <= 1'b1;
                        r_state       <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_have_block) begin
                        r_data_valid <= 1'b1;
                        r_start_data <= 1'b1;
                        r_sof        <= r_first;
                        r_eof        <= w_last_blk;
                        r_first      <= 1'b0;
                        r_idx        <= IW'(1);
                        r_state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    r_data_valid <= 1'b1;
                    r_eof        <= w_last_blk;
                    r_idx        <= r_idx + 1'b1;
                    if (w_last_idx) begin
                        r_blocks_left <= r_blocks_left - 32'd1;
                        if (w_last_blk) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_gap   <= '0;
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (r_gap == GW'(GAP_CYCLES - 1)) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_block_stream_sender.sv
// Bench for block_stream_sender: event-level FIFO/frame model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_block_stream_sender;
    localparam int TS  = 4;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [31:0] blocks_per_frame;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        start_data;
    logic        start_of_frame;
    logic        end_of_frame;
    logic        busy;
    logic        frame_done;

    block_stream_sender #(
        .DATA_WIDTH   (8),
        .TOTAL_SAMPLES(TS),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_start     (frame_start),
        .blocks_per_frame(blocks_per_frame),
        .s_valid         (s_valid),
        .s_data          (s_data),
        .s_ready         (s_ready),
        .data_out        (data_out),
        .data_valid      (data_valid),
        .start_data      (start_data),
        .start_of_frame  (start_of_frame),
        .end_of_frame    (end_of_frame),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
        end
    endtask

    // model state
    logic [7:0]  mq[$];
    int          mcount = 0;
    int          cnt_before;
    bit          push_pend = 0;
    bit          fs_pend = 0;
    bit          busy_m = 0;
    bit          exp_done = 0;
    bit          nxt_done;
    logic [7:0]  pend_d = 0;
    logic [7:0]  last_out = 0;
    logic [7:0]  exp_d;
    logic [31:0] bpf_pend = 0;
    logic [31:0] btotal = 0;
    logic [31:0] bdone = 0;
    int          sib = 0;
    int          gap_m = 0;
    int          cyc = 0;
    int          busy_rise = 0;
    int          done_cnt = 0;
    int          push_total = 0;
    int          log_d[$];
    int          log_sd[$];
    int          log_sof[$];
    int          log_eof[$];
    int          log_gap[$];
    int          log_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_data_out", data_out, 0);
            chk("rst_data_valid", data_valid, 0);
            chk("rst_start_data", start_data, 0);
            chk("rst_sof", start_of_frame, 0);
            chk("rst_eof", end_of_frame, 0);
            chk("rst_busy", busy, 0);
            chk("rst_frame_done", frame_done, 0);
            chk("rst_s_ready", s_ready, 1);
            mq.delete();
            mcount = 0; push_pend = 0; fs_pend = 0; busy_m = 0;
            exp_done = 0; sib = 0; bdone = 0; btotal = 0;
            last_out = 0; gap_m = 0;
        end else begin
            cnt_before = mcount;
            nxt_done = 0;
            if (exp_done) begin
                busy_m = 0;
            end else if (fs_pend && bpf_pend != 0 && !busy_m) begin
                busy_m = 1; btotal = bpf_pend; bdone = 0; sib = 0;
                busy_rise = cyc;
            end
            chk("frame_done", frame_done, exp_done);
            if (frame_done) done_cnt++;
            chk("busy", busy, busy_m);
            if (data_valid) begin
                if (!busy_m || mq.size() == 0) begin
                    chk("dv_outside_frame", data_valid, 0);
                end else begin
                    exp_d = mq.pop_front();
                    mcount--;
                    chk("data", data_out, exp_d);
                    chk("start_data", start_data, sib == 0);
                    chk("start_of_frame", start_of_frame, sib == 0 && bdone == 0);
                    chk("end_of_frame", end_of_frame, bdone == btotal - 1);
                    if (sib == 0) begin
                        chk("block_full", cnt_before >= TS, 1);
                        if (bdone != 0) chk("gap_min", gap_m >= GAP, 1);
                    end
                    log_d.push_back(data_out);
                    log_sd.push_back(start_data);
                    log_sof.push_back(start_of_frame);
                    log_eof.push_back(end_of_frame);
                    log_gap.push_back(gap_m);
                    log_cyc.push_back(cyc);
                    last_out = exp_d;
                    gap_m = 0;
                    sib++;
                    if (sib == TS) begin
                        sib = 0;
                        bdone++;
                        if (bdone == btotal) nxt_done = 1;
                    end
                end
            end else begin
                chk("data_hold", data_out, last_out);
                chk("idle_start_data", start_data, 0);
                chk("idle_sof", start_of_frame, 0);
                chk("idle_eof", end_of_frame, 0);
                if (busy_m) chk("bubble", sib, 0);
                gap_m++;
            end
            if (push_pend) begin
                mq.push_back(pend_d);
                mcount++;
                push_total++;
            end
            chk("s_ready", s_ready, mcount < 2 * TS);
            push_pend = s_valid && s_ready;
            pend_d    = s_data;
            fs_pend   = frame_start;
            bpf_pend  = blocks_per_frame;
            exp_done  = nxt_done;
        end
    end

    // upstream source: one pixel per (src_gap+1) cycles when ready
    logic [7:0] src_q[$];
    int         src_gap = 0;
    int         wcnt = 0;
    bit         hs;

    initial begin
        s_valid = 0;
        s_data  = 0;
        forever begin
            @(negedge clk);
            hs = s_valid && s_ready && rst_n;
            @(posedge clk);
            #1;
            if (hs && src_q.size() > 0) begin
                void'(src_q.pop_front());
                wcnt = src_gap;
            end
            if (src_q.size() > 0 && wcnt == 0) begin
                s_valid = 1;
                s_data  = src_q[0];
            end else begin
                s_valid = 0;
                if (wcnt > 0) wcnt--;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_d.delete(); log_sd.delete(); log_sof.delete();
        log_eof.delete(); log_gap.delete(); log_cyc.delete();
        done_cnt = 0;
    endtask

    task automatic start_frame(input logic [31:0] bpf);
        @(posedge clk);
        #1;
        frame_start      = 1;
        blocks_per_frame = bpf;
        @(posedge clk);
        #1;
        frame_start      = 0;
        blocks_per_frame = 32'd77;
    endtask

    task automatic wait_done(input int maxc, input string nm);
        int n;
        n = 0;
        while (done_cnt == 0 && n < maxc) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({nm, "_done_seen"}, done_cnt != 0, 1);
    endtask

    int p0;
    int n;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0;
        frame_start = 0;
        blocks_per_frame = 0;
        cycles(3);
        @(posedge clk);
        #1;
        rst_n = 1;
        cycles(2);
        chk("a_busy_idle", busy, 0);
        chk("a_s_ready_idle", s_ready, 1);

        // zero-block request is ignored
        clear_logs();
        start_frame(0);
        cycles(5);
        chk("b_zero_busy", busy, 0);
        chk("b_zero_done", done_cnt, 0);

        // prefilled frame with backpressure during prefill
        clear_logs();
        src_gap = 0;
        p0 = push_total;
        for (int i = 1; i <= 16; i++) src_q.push_back(8'(4 * i));
        cycles(15);
        chk("c_prefill_pushes", push_total - p0, 8);
        chk("c_prefill_ready", s_ready, 0);
        start_frame(4);
        wait_done(200, "c");
        cycles(4);
        chk("c_len", log_d.size(), 16);
        chk("c_done_once", done_cnt, 1);
        if (log_d.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                chk("c_data", log_d[i], 4 * (i + 1));
                chk("c_sof", log_sof[i], i == 0);
                chk("c_eof", log_eof[i], i >= 12);
            end
            chk("c_sd_4", log_sd[0], 1);
            chk("c_sd_20", log_sd[4], 1);
            chk("c_sd_36", log_sd[8], 1);
            chk("c_sd_52", log_sd[12], 1);
            chk("c_sd_8", log_sd[1], 0);
            chk("c_gap1", log_gap[4], 2);
            chk("c_gap2", log_gap[8], 2);
            chk("c_gap3", log_gap[12], 2);
            chk("c_latency", log_cyc[0] - busy_rise, 1);
        end

        // starved source plus ignored mid-frame request
        clear_logs();
        src_gap = 2;
        for (int i = 0; i < 8; i++) src_q.push_back(8'(100 + i));
        start_frame(2);
        cycles(10);
        start_frame(5);
        wait_done(300, "d");
        cycles(30);
        chk("d_len", log_d.size(), 8);
        chk("d_done_once", done_cnt, 1);
        chk("d_busy_after", busy, 0);
        if (log_d.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk("d_data", log_d[i], 100 + i);
                chk("d_eof", log_eof[i], i >= 4);
            end
        end

        // backpressure with no frame, then drain two blocks
        clear_logs();
        src_gap = 0;
        p0 = push_total;
        for (int i = 0; i < 9; i++) src_q.push_back(8'(200 + i));
        cycles(20);
        chk("e_pushes", push_total - p0, 8);
        chk("e_ready_low", s_ready, 0);
        start_frame(2);
        wait_done(200, "e");
        cycles(5);
        chk("e_len", log_d.size(), 8);
        if (log_d.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("e_data", log_d[i], 200 + i);
        end

        // single-block frame
        clear_logs();
        for (int i = 0; i < 3; i++) src_q.push_back(8'(209 + i));
        cycles(10);
        start_frame(1);
        wait_done(100, "f");
        cycles(5);
        chk("f_len", log_d.size(), 4);
        chk("f_done_once", done_cnt, 1);
        if (log_d.size() == 4) begin
            chk("f_sof0", log_sof[0], 1);
            chk("f_sd0", log_sd[0], 1);
            chk("f_sd1", log_sd[1], 0);
            for (int i = 0; i < 4; i++) begin
                chk("f_data", log_d[i], 208 + i);
                chk("f_eof", log_eof[i], 1);
            end
        end

        // mid-frame reset on the second sample of block 2
        clear_logs();
        for (int i = 1; i <= 16; i++) src_q.push_back(8'(i));
        cycles(12);
        start_frame(4);
        n = 0;
        while (!(bdone == 1 && sib == 2) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("g_reached_block2", bdone == 1 && sib == 2, 1);
        src_q.delete();
        s_valid = 0;
        rst_n = 0;
        #1;
        chk("g_async_dv", data_valid, 0);
        chk("g_async_busy", busy, 0);
        chk("g_async_data", data_out, 0);
        chk("g_async_eof", end_of_frame, 0);
        chk("g_async_ready", s_ready, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
        clear_logs();
        cycles(8);
        chk("g_no_resume", log_d.size(), 0);
        chk("g_busy_after", busy, 0);
        for (int i = 0; i < 4; i++) src_q.push_back(8'(50 + i));
        cycles(8);
        start_frame(1);
        wait_done(100, "g");
        cycles(3);
        chk("g_len", log_d.size(), 4);
        if (log_d.size() == 4) begin
            chk("g_sof", log_sof[0], 1);
            chk("g_first", log_d[0], 50);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
